// File: rtl/btn_debounce_if.sv
// Signal bundle for the button debouncer. The debouncer takes the slave view.
// The stimulus side (button model or testbench) takes the master view.
interface btn_debounce_if;
  logic       btn_in;
  logic       q;
  logic       rise;
  logic       fall;
  logic [7:0] press_cnt;

  modport master (
    output btn_in,
    input  q,
    input  rise,
    input  fall,
    input  press_cnt
  );

  modport slave (
    input  btn_in,
    output q,
    output rise,
    output fall,
    output press_cnt
  );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: a 2-flop synchroniser followed by a counter-qualified
// 4-state FSM. Produces a clean level, rise/fall pulses and a press counter.
module btn_debounce #(
  parameter int unsigned STABLE_CNT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  btn_debounce_if.slave btn_if
);

  localparam logic [1:0] S_LOW      = 2'd0;
  localparam logic [1:0] S_CHK_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;
  localparam logic [1:0] S_CHK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1_q;
  logic             btn_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_if.btn_in;
      btn_s_q <= sync1_q;
    end
  end

  // Rejection in a CHK state returns to the prior stable state without
  // touching q, so q only ever moves on a CHK->stable acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      S_LOW: begin
        if (btn_s_q) begin
          state_d = S_CHK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      S_CHK_HIGH: begin
        if (!btn_s_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_HIGH;
          q_d         = 1'b1;
          rise_d      = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!btn_s_q) begin
          state_d = S_CHK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      S_CHK_LOW: begin
        if (btn_s_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOW;
      cnt_q       <= '0;
      q_q         <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign btn_if.q         = q_q;
  assign btn_if.rise      = rise_q;
  assign btn_if.fall      = fall_q;
  assign btn_if.press_cnt = press_cnt_q;

  a_pulse_excl: assert property (@(posedge clk) !(rise_q && fall_q));
  a_rise_lvl:   assert property (@(posedge clk) rise_q |-> q_q);
  a_fall_lvl:   assert property (@(posedge clk) fall_q |-> !q_q);

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with hand-computed expectations at the
// default STABLE_CNT=16: an accepted level shows on q 18 cycles after it is driven.
module tb_btn_debounce;

  logic clk;
  logic rst;
  btn_debounce_if bif ();

  btn_debounce #(.STABLE_CNT(16), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rise_seen = 0;
  int unsigned fall_seen = 0;
  int unsigned q_hi_seen = 0;
  int unsigned both_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bif.rise) rise_seen++;
      if (bif.fall) fall_seen++;
      if (bif.q) q_hi_seen++;
      if (bif.rise && bif.fall) both_seen++;
    end
  endtask

  task automatic clear_counts();
    rise_seen = 0;
    fall_seen = 0;
    q_hi_seen = 0;
    both_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.btn_in = 1'b0;
    run(3);
    rst = 1'b0;
    clear_counts();
  endtask

  initial begin
    rst = 1'b1;
    bif.btn_in = 1'b0;
    run(2);
    check("rst_outs", {bif.q, bif.rise, bif.fall, bif.press_cnt}, 32'd0);

    // Idle after reset
    rst = 1'b0;
    clear_counts();
    run(40);
    check("idle_q", q_hi_seen, 0);
    check("idle_rise", rise_seen, 0);
    check("idle_fall", fall_seen, 0);
    check("idle_press", bif.press_cnt, 0);

    // Clean press: q/rise appear after the 18th sample (edge 17)
    bif.btn_in = 1'b1;
    for (int unsigned i = 1; i <= 30; i++) begin
      run(1);
      check("press_qrf", {bif.q, bif.rise, bif.fall}, {(i >= 18), (i == 18), 1'b0});
    end
    check("press_cnt1", bif.press_cnt, 1);
    bif.btn_in = 1'b0;
    for (int unsigned i = 1; i <= 30; i++) begin
      run(1);
      check("rel_qrf", {bif.q, bif.rise, bif.fall}, {(i < 18), 1'b0, (i == 18)});
    end
    check("rel_press", bif.press_cnt, 1);

    // Bounce: toggle every 3 cycles for 20 cycles, then hold high
    do_reset();
    for (int unsigned i = 0; i < 20; i++) begin
      bif.btn_in = (((i / 3) % 2) == 0);
      run(1);
    end
    check("bnc_rise_tog", rise_seen, 0);
    check("bnc_fall_tog", fall_seen, 0);
    bif.btn_in = 1'b1;
    run(30);
    check("bnc_rise", rise_seen, 1);
    check("bnc_q", bif.q, 1);
    check("bnc_press", bif.press_cnt, 1);

    // Glitch: 10 high cycles then low
    do_reset();
    bif.btn_in = 1'b1;
    run(10);
    bif.btn_in = 1'b0;
    run(30);
    check("gl_q", q_hi_seen, 0);
    check("gl_rise", rise_seen, 0);
    check("gl_press", bif.press_cnt, 0);

    // Boundary: 15 high samples rejected, 16 accepted
    do_reset();
    bif.btn_in = 1'b1;
    run(15);
    bif.btn_in = 1'b0;
    run(30);
    check("bd15_rise", rise_seen, 0);
    bif.btn_in = 1'b1;
    run(16);
    bif.btn_in = 1'b0;
    run(30);
    check("bd16_rise", rise_seen, 1);
    check("bd16_fall", fall_seen, 1);
    check("bd16_press", bif.press_cnt, 1);

    // Release glitch while high: no fall, q stays 1
    bif.btn_in = 1'b1;
    run(25);
    clear_counts();
    bif.btn_in = 1'b0;
    run(5);
    bif.btn_in = 1'b1;
    run(30);
    check("rg_fall", fall_seen, 0);
    check("rg_q", q_hi_seen, 35);
    check("rg_press", bif.press_cnt, 2);

    // Wrap: 256 presses
    do_reset();
    for (int unsigned p = 1; p <= 256; p++) begin
      bif.btn_in = 1'b1;
      run(20);
      if (p == 255) check("wrap_255", bif.press_cnt, 255);
      if (p == 256) check("wrap_0", bif.press_cnt, 0);
      bif.btn_in = 1'b0;
      run(20);
    end
    check("wrap_rises", rise_seen, 256);
    check("wrap_falls", fall_seen, 256);
    check("wrap_both", both_seen, 0);

    // Reset mid-CHK with press_cnt already nonzero
    do_reset();
    bif.btn_in = 1'b1;
    run(20);
    bif.btn_in = 1'b0;
    run(20);
    check("mc_pre_press", bif.press_cnt, 1);
    bif.btn_in = 1'b1;
    run(12);
    rst = 1'b1;
    run(1);
    check("mc_rst_outs", {bif.q, bif.rise, bif.fall, bif.press_cnt}, 32'd0);
    rst = 1'b0;
    run(17);
    check("mc_q_pre", {bif.q, bif.rise}, 2'b00);
    run(1);
    check("mc_q_acc", {bif.q, bif.rise}, 2'b11);
    check("mc_press", bif.press_cnt, 1);
    run(1);
    check("mc_rise_end", {bif.q, bif.rise}, 2'b10);

    // Reset in the cycle a rise would be produced drops the pulse
    do_reset();
    bif.btn_in = 1'b1;
    run(17);
    rst = 1'b1;
    run(1);
    check("rp_outs", {bif.q, bif.rise, bif.press_cnt}, 32'd0);
    rst = 1'b0;
    run(5);
    check("rp_after", {bif.q, bif.rise}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
